framebuffer_scanout: RTL and testbench

Reads the 80x60 4-bit-per-channel framebuffer and drives a 640x480@60 VGA-style display: it generates horizontal/vertical timing, issues framebuffer read addresses with integer upscaling, compensates for the framebuffer's 1-cycle read latency, and outputs pixel colour with aligned syncs. It is the read-side counterpart to the rasterizer, which owns the framebuffer write port. It also emits a vertical-blank pulse that serves as the rasterizer's `i_go` trigger.

---
 rtl/display_pkg.sv | 41 ++++
 rtl/display_timing_counter.sv | 65 ++++++
 rtl/framebuffer_scanout.sv | 109 ++++++++++
 tb/tb_framebuffer_scanout.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Display timing defaults and framebuffer geometry shared by the scanout and the rasterizer.
package display_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_HSYNC_START = DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC;
  localparam int DEF_VSYNC_START = DEF_V_ACTIVE + DEF_V_FRONT;
  localparam int DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC;

  localparam int DEF_HORIZ_RESOLUTION = 80;
  localparam int DEF_VERT_RESOLUTION  = 60;
  localparam int DEF_SCALE            = 8;

  // Syncs are carried at pin polarity (active-low).
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic vblank_start;
  } timing_t;

  localparam timing_t TIMING_BLANK = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1, vblank_start: 1'b0};

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb_t;

endpackage

// File: rtl/display_timing_counter.sv
// Stage 0 of the scanout: h/v raster counters with active, sync and vblank-start decode.
module display_timing_counter
  import display_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int H_CNT_W = $clog2(H_TOTAL),
  localparam int V_CNT_W = $clog2(V_TOTAL)
) (
  input  logic               i_clk,
  input  logic               i_srst_n,
  input  logic               i_enable,
  output logic [H_CNT_W-1:0] o_h_count,
  output logic [V_CNT_W-1:0] o_v_count,
  output timing_t            o_timing
);

  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [H_CNT_W-1:0] h_count_reg;
  logic [V_CNT_W-1:0] v_count_reg;
  logic               h_wrap;
  logic               v_wrap;

  assign h_wrap = (h_count_reg == H_CNT_W'(H_TOTAL - 1));
  assign v_wrap = (v_count_reg == V_CNT_W'(V_TOTAL - 1));

  always_ff @(posedge i_clk) begin
    if (!i_srst_n || !i_enable) begin
      h_count_reg <= '0;
      v_count_reg <= '0;
    end else if (h_wrap) begin
      h_count_reg <= '0;
      v_count_reg <= v_wrap ? '0 : v_count_reg + 1'b1;
    end else begin
      h_count_reg <= h_count_reg + 1'b1;
    end
  end

  // Decode is gated by enable so the cycle enable drops already reads as blank.
  always_comb begin
    o_timing = TIMING_BLANK;
    if (i_enable) begin
      o_timing.active       = (h_count_reg < H_CNT_W'(H_ACTIVE)) && (v_count_reg < V_CNT_W'(V_ACTIVE));
      o_timing.hsync        = !((h_count_reg >= H_CNT_W'(HS_START)) && (h_count_reg < H_CNT_W'(HS_END)));
      o_timing.vsync        = !((v_count_reg >= V_CNT_W'(VS_START)) && (v_count_reg < V_CNT_W'(VS_END)));
      o_timing.vblank_start = (h_count_reg == '0) && (v_count_reg == V_CNT_W'(V_ACTIVE));
    end
  end

  assign o_h_count = h_count_reg;
  assign o_v_count = v_count_reg;

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer-to-VGA scanout: upscaled read addressing, read-latency compensation and aligned outputs.
module framebuffer_scanout
  import display_pkg::*;
#(
  parameter int HORIZ_RESOLUTION = DEF_HORIZ_RESOLUTION,
  parameter int VERT_RESOLUTION  = DEF_VERT_RESOLUTION,
  parameter int SCALE            = DEF_SCALE,
  parameter int H_ACTIVE         = HORIZ_RESOLUTION * SCALE,
  parameter int H_FRONT          = DEF_H_FRONT,
  parameter int H_SYNC           = DEF_H_SYNC,
  parameter int H_BACK           = DEF_H_BACK,
  parameter int V_ACTIVE         = VERT_RESOLUTION * SCALE,
  parameter int V_FRONT          = DEF_V_FRONT,
  parameter int V_SYNC           = DEF_V_SYNC,
  parameter int V_BACK           = DEF_V_BACK,
  localparam int HADDR_W         = $clog2(HORIZ_RESOLUTION),
  localparam int VADDR_W         = $clog2(VERT_RESOLUTION)
) (
  input  logic               i_clk,
  input  logic               i_srst_n,
  input  logic               i_enable,
  output logic [VADDR_W-1:0] o_vert_read_addr,
  output logic [HADDR_W-1:0] o_horiz_read_addr,
  output logic               o_read_en,
  input  logic [3:0]         i_red,
  input  logic [3:0]         i_green,
  input  logic [3:0]         i_blue,
  output logic [3:0]         o_red,
  output logic [3:0]         o_green,
  output logic [3:0]         o_blue,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_active,
  output logic               o_vblank_start
);

  localparam int SCALE_SHIFT = $clog2(SCALE);
  localparam int H_CNT_W     = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam int V_CNT_W     = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);

  logic [H_CNT_W-1:0] h_count;
  logic [V_CNT_W-1:0] v_count;
  timing_t            timing0;

  display_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .i_clk     (i_clk),
    .i_srst_n  (i_srst_n),
    .i_enable  (i_enable),
    .o_h_count (h_count),
    .o_v_count (v_count),
    .o_timing  (timing0)
  );

  logic [HADDR_W-1:0] horiz_addr_next;
  logic [VADDR_W-1:0] vert_addr_next;
  logic [HADDR_W-1:0] horiz_addr_reg;
  logic [VADDR_W-1:0] vert_addr_reg;
  logic               read_en_reg;
  timing_t [2:0]      timing_pipe_reg;
  rgb_t               rgb_reg;

  // SCALE is a power of two, so the upscale divide is a plain shift.
  always_comb begin
    horiz_addr_next = '0;
    vert_addr_next  = '0;
    if (timing0.active) begin
      horiz_addr_next = HADDR_W'(h_count >> SCALE_SHIFT);
      vert_addr_next  = VADDR_W'(v_count >> SCALE_SHIFT);
    end
  end

  // Index 0 is stage 1, index 2 drives the pins; colour is captured alongside stage 3.
  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      horiz_addr_reg  <= '0;
      vert_addr_reg   <= '0;
      read_en_reg     <= 1'b0;
      timing_pipe_reg <= {3{TIMING_BLANK}};
      rgb_reg         <= '0;
    end else begin
      horiz_addr_reg  <= horiz_addr_next;
      vert_addr_reg   <= vert_addr_next;
      read_en_reg     <= timing0.active;
      timing_pipe_reg <= {timing_pipe_reg[1:0], timing0};
      rgb_reg         <= timing_pipe_reg[1].active ? rgb_t'({i_red, i_green, i_blue}) : '0;
    end
  end

  assign o_horiz_read_addr = horiz_addr_reg;
  assign o_vert_read_addr  = vert_addr_reg;
  assign o_read_en         = read_en_reg;
  assign o_red             = rgb_reg.red;
  assign o_green           = rgb_reg.green;
  assign o_blue            = rgb_reg.blue;
  assign o_hsync           = timing_pipe_reg[2].hsync;
  assign o_vsync           = timing_pipe_reg[2].vsync;
  assign o_active          = timing_pipe_reg[2].active;
  assign o_vblank_start    = timing_pipe_reg[2].vblank_start;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: shortened vertical timing, real horizontal timing, per-cycle scoreboard.
module tb_framebuffer_scanout;

  localparam int HRES = 80, VRES = 3, SCALE = 8;
  localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = 800;
  localparam int VA = 24, VF = 2, VS = 2, VB = 2, VT = 30;
  localparam int HAW = 7, VAW = 2;

  logic           clk = 1'b0;
  logic           srst_n = 1'b0;
  logic           enable = 1'b1;
  logic [VAW-1:0] vaddr;
  logic [HAW-1:0] haddr;
  logic           read_en;
  logic [3:0]     fb_red = '0, fb_green = '0, fb_blue = '0;
  logic [3:0]     red, green, blue;
  logic           hsync, vsync, active, vblank_start;

  always #5 clk = ~clk;

  framebuffer_scanout #(
    .HORIZ_RESOLUTION (HRES), .VERT_RESOLUTION (VRES), .SCALE (SCALE),
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) dut (
    .i_clk (clk), .i_srst_n (srst_n), .i_enable (enable),
    .o_vert_read_addr (vaddr), .o_horiz_read_addr (haddr), .o_read_en (read_en),
    .i_red (fb_red), .i_green (fb_green), .i_blue (fb_blue),
    .o_red (red), .o_green (green), .o_blue (blue),
    .o_hsync (hsync), .o_vsync (vsync), .o_active (active), .o_vblank_start (vblank_start)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // Contents of the framebuffer model, addressed by column/row.
  function automatic logic [11:0] fb_rgb(input int col, input int row);
    logic [3:0] r, g, b;
    r = 4'(col % 16);
    g = 4'((row * 3 + 1) % 16);
    b = 4'((col / 16 + row) % 16);
    return {r, g, b};
  endfunction

  typedef struct {
    logic act, hs, vs, vbl;
    int   col, row;
  } exp_t;

  function automatic exp_t decode(input int h, input int v, input logic en);
    exp_t e;
    e.act = en && (h < HA) && (v < VA);
    e.hs  = !(en && (h >= HA + HF) && (h < HA + HF + HS));
    e.vs  = !(en && (v >= VA + VF) && (v < VA + VF + VS));
    e.vbl = en && (h == 0) && (v == VA);
    e.col = e.act ? h / SCALE : 0;
    e.row = e.act ? v / SCALE : 0;
    return e;
  endfunction

  // {haddr, vaddr, read_en, rgb, hsync, vsync, active, vblank_start} at reset / idle
  localparam logic [25:0] RESET_VEC = {22'd0, 4'b1100};

  function automatic logic [25:0] out_vec();
    return {haddr, vaddr, read_en, red, green, blue, hsync, vsync, active, vblank_start};
  endfunction

  task automatic check_reset_outputs(input string name);
    check(name, 32'(out_vec()), 32'(RESET_VEC));
  endtask

  // Model counter for the current cycle, and the counter whose stage-1 outputs are visible.
  int   m_h = 0, m_v = 0;
  int   vis_h = -1, vis_v = -1;
  exp_t sb_q[$];

  initial begin : scoreboard
    exp_t        e, o;
    logic        s, en;
    int          s1_col, s1_row, src_h, src_v;
    logic        s1_re;
    logic [11:0] rgb_exp;
    logic [25:0] exp_vec;
    forever begin
      @(posedge clk);
      s = srst_n;
      en = enable;
      if (!s) begin
        sb_q.delete();
        s1_col = 0; s1_row = 0; s1_re = 1'b0;
        src_h = -1; src_v = -1;
        m_h = 0; m_v = 0;
      end else begin
        e = decode(m_h, m_v, en);
        sb_q.push_back(e);
        s1_col = e.col; s1_row = e.row; s1_re = e.act;
        src_h = m_h; src_v = m_v;
        if (!en) begin
          m_h = 0; m_v = 0;
        end else if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h++;
        end
      end
      #1;
      vis_h = src_h;
      vis_v = src_v;
      if (sb_q.size() == 3) o = sb_q.pop_front();
      else o = decode(0, 0, 1'b0);
      rgb_exp = o.act ? fb_rgb(o.col, o.row) : 12'd0;
      exp_vec = {7'(s1_col), 2'(s1_row), s1_re, rgb_exp, o.hs, o.vs, o.act, o.vbl};
      check($sformatf("cycle v%0d h%0d", src_v, src_h), 32'(out_vec()), 32'(exp_vec));
    end
  end

  // Framebuffer model: data for the address read in one cycle appears in the next; garbage otherwise.
  initial begin : fbmem
    logic rd;
    int   c, r;
    forever begin
      @(negedge clk);
      rd = read_en;
      c = int'(haddr);
      r = int'(vaddr);
      @(posedge clk);
      #1;
      if (rd === 1'b1) {fb_red, fb_green, fb_blue} = fb_rgb(c, r);
      else {fb_red, fb_green, fb_blue} = 12'($urandom);
    end
  end

  typedef struct {
    int   h;
    int   exp_haddr;
    int   exp_vaddr;
    logic exp_re;
  } avec_t;

  initial begin : main
    avec_t avec[10];
    int first_act, hs_fall, hs_len, vs_fall, vs_len, vbl_cnt, vbl_at, blank_bad, lat, budget;

    avec[0] = '{0, 0, 2, 1'b1};    avec[1] = '{7, 0, 2, 1'b1};
    avec[2] = '{8, 1, 2, 1'b1};    avec[3] = '{15, 1, 2, 1'b1};
    avec[4] = '{16, 2, 2, 1'b1};   avec[5] = '{320, 40, 2, 1'b1};
    avec[6] = '{632, 79, 2, 1'b1}; avec[7] = '{639, 79, 2, 1'b1};
    avec[8] = '{640, 0, 0, 1'b0};  avec[9] = '{700, 0, 0, 1'b0};

    // Reset hold, release, then one full frame measured from release.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset_outputs($sformatf("rst_hold%0d", i));
    end
    srst_n = 1'b1;
    first_act = 0; hs_fall = 0; hs_len = 0; vs_fall = 0; vs_len = 0;
    vbl_cnt = 0; vbl_at = 0; blank_bad = 0;
    for (int n = 1; n <= VT * HT; n++) begin
      @(negedge clk);
      if (active === 1'b1 && first_act == 0) first_act = n;
      if (hsync === 1'b0 && n <= HT + 2) begin
        if (hs_fall == 0) hs_fall = n;
        hs_len++;
      end
      if (vsync === 1'b0) begin
        if (vs_fall == 0) vs_fall = n;
        vs_len++;
      end
      if (vblank_start === 1'b1) begin
        vbl_cnt++;
        vbl_at = n;
      end
      if (active !== 1'b1 && {red, green, blue} !== 12'd0) blank_bad++;
    end
    check("first_active_latency", first_act, 3);
    check("hsync_fall", hs_fall, HA + HF + 3);
    check("hsync_width", hs_len, HS);
    check("vsync_fall", vs_fall, (VA + VF) * HT + 3);
    check("vsync_width", vs_len, VS * HT);
    check("vblank_count", vbl_cnt, 1);
    check("vblank_pos", vbl_at, VA * HT + 3);
    check("blank_colour", blank_bad, 0);
    $display("phase frame: checks=%0d errors=%0d", checks, errors);

    // Address scaling along line 17 of the next frame.
    for (int i = 0; i < 10; i++) begin
      budget = 0;
      while (!(vis_v == 17 && vis_h == avec[i].h) && budget < 2 * VT * HT) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 2 * VT * HT) timeout_fail($sformatf("addr_wait_h%0d", avec[i].h));
      else begin
        check($sformatf("haddr_h%0d", avec[i].h), 32'(haddr), avec[i].exp_haddr);
        check($sformatf("vaddr_h%0d", avec[i].h), 32'(vaddr), avec[i].exp_vaddr);
        check($sformatf("read_en_h%0d", avec[i].h), 32'(read_en), 32'(avec[i].exp_re));
      end
      $display("vector h=%0d haddr=%0d vaddr=%0d read_en=%0b", avec[i].h, haddr, vaddr, read_en);
    end

    // Colour emerges two cycles after its read address.
    budget = 0;
    while (!(vis_v == 18 && vis_h == 100) && budget < 4 * HT) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 4 * HT) timeout_fail("align_wait");
    else begin
      repeat (2) @(negedge clk);
      check("align_rgb", 32'({active, red, green, blue}), 32'({1'b1, fb_rgb(12, 2)}));
    end
    $display("phase align: checks=%0d errors=%0d", checks, errors);

    // Enable drop mid-line.
    budget = 0;
    while (!(m_v == 20 && m_h == 300) && budget < 2 * VT * HT) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 2 * VT * HT) timeout_fail("enable_drop_wait");
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_read_en", 32'(read_en), 0);
    repeat (2) @(negedge clk);
    check("en_drop_active", 32'(active), 0);
    repeat (7) @(negedge clk);
    check_reset_outputs("en_low_idle");
    enable = 1'b1;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) check("resume_addr", 32'({read_en, haddr, vaddr}), 32'({1'b1, 7'd0, 2'd0}));
      if (active === 1'b1 && lat == 0) lat = n;
    end
    check("resume_active_latency", lat, 3);
    $display("phase enable: checks=%0d errors=%0d", checks, errors);

    // One-cycle reset mid-frame, then time to the next vblank.
    budget = 0;
    while (!(m_v == 12 && m_h == 100) && budget < 2 * VT * HT) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 2 * VT * HT) timeout_fail("midrst_wait");
    srst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst_outputs");
    srst_n = 1'b1;
    first_act = 0;
    vbl_at = 0;
    for (int n = 1; n <= VT * HT; n++) begin
      @(negedge clk);
      if (active === 1'b1 && first_act == 0) first_act = n;
      if (vblank_start === 1'b1) begin
        vbl_at = n;
        break;
      end
    end
    check("midrst_first_active", first_act, 3);
    check("midrst_vblank_pos", vbl_at, VA * HT + 3);
    $display("phase midrst: checks=%0d errors=%0d", checks, errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
